// File: rtl/payload_match_collector.sv
// payload_match_collector
// Snapshots the sticky match flags of a group of payload engines once the
// packet's payload has drained through the engine pipelines. The matched
// engine IDs are then streamed, lowest ID first, over a valid/ready
// interface. m_last marks the final ID of a packet.
//
// Optional build macro: PAYLOAD_COLLECTOR_STATS_EN
//   defined   -> saturating 32-bit packet/hit counters are built
//   undefined -> stat_pkts / stat_hits are tied to zero
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for an en-qualified eod
// ST_DRAIN | counting en cycles until the engine pipelines have drained
// ST_SCAN  | emitting matched IDs from the private snapshot

module payload_match_collector #(
  parameter int NUM_ENGINES = 64,
  parameter int ID_W        = 6,
  parameter int DRAIN       = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] eng_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ID_W-1:0]        m_id,
  output logic                   m_last,
  output logic                   busy,
  output logic                   pkt_drop,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_hits
);

  localparam int CNT_W = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);
  localparam logic [NUM_ENGINES-1:0] VEC_ONE = NUM_ENGINES'(1);
  localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(DRAIN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_ENGINES-1:0] snap;
  logic [NUM_ENGINES-1:0] sel_onehot;
  logic [NUM_ENGINES-1:0] scan_src;
  logic [ID_W-1:0]        low_id;
  logic                   low_found;
  logic                   src_single;

  // Vector the encoder works on: the live engine flags at capture time,
  // otherwise the snapshot with the currently presented ID removed, so the
  // next ID is ready the cycle after a handshake.
  always_comb begin
    sel_onehot = VEC_ONE << m_id;
    scan_src   = (state == ST_DRAIN) ? eng_out : (snap & ~sel_onehot);
    src_single = ((scan_src & (scan_src - VEC_ONE)) == '0);
  end

  // Lowest-set-bit priority encoder.
  always_comb begin
    low_id    = '0;
    low_found = 1'b0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (scan_src[i]) begin
        low_id    = ID_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Sequencing FSM with registered stream outputs and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      snap     <= '0;
      m_valid  <= 1'b0;
      m_id     <= '0;
      m_last   <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      pkt_drop <= 1'b0;
      case (state)
        ST_IDLE: begin
          // sod together with eod is a one-byte packet, handled as eod.
          if (en && eod) begin
            state <= ST_DRAIN;
            cnt   <= CNT_INIT;
          end
        end

        ST_DRAIN: begin
          if (sod) begin
            // Engines were cleared mid-drain; their flags are meaningless.
            pkt_drop <= 1'b1;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            // A further packet end cannot be queued behind this one.
            if (en && eod) begin
              pkt_drop <= 1'b1;
            end
            if (cnt == '0) begin
              snap <= eng_out;
              if (low_found) begin
                state   <= ST_SCAN;
                m_valid <= 1'b1;
                m_id    <= low_id;
                m_last  <= src_single;
              end else begin
                state <= ST_IDLE;
              end
            end else if (en) begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end

        ST_SCAN: begin
          // The scan works from the snapshot, so sod is ignored here.
          if (en && eod) begin
            pkt_drop <= 1'b1;
          end
          if (m_ready) begin
            if (m_last) begin
              state   <= ST_IDLE;
              snap    <= '0;
              m_valid <= 1'b0;
              m_id    <= '0;
              m_last  <= 1'b0;
            end else begin
              snap   <= scan_src;
              m_id   <= low_id;
              m_last <= src_single;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          m_valid <= 1'b0;
          m_id    <= '0;
          m_last  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef PAYLOAD_COLLECTOR_STATS_EN
  logic cap_evt;
  logic hit_evt;

  assign cap_evt = (state == ST_DRAIN) && !sod && (cnt == '0);
  assign hit_evt = m_valid && m_ready;

  // Saturating packet and hit counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_hits <= '0;
    end else begin
      if (cap_evt && (stat_pkts != 32'hFFFF_FFFF)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (hit_evt && (stat_hits != 32'hFFFF_FFFF)) begin
        stat_hits <= stat_hits + 32'd1;
      end
    end
  end
`else
  assign stat_pkts = '0;
  assign stat_hits = '0;
`endif

endmodule
